signed_bcd_display_encoder: RTL and testbench

Sequential signed-binary-to-display encoder that consumes the ALU result word and produces registered BCD digits, a sign flag and active-low 7-segment patterns. It converts with an iterative shift-and-add-3 (double-dabble) engine behind a start/busy/done handshake. It sits directly downstream of the ALU. It replaces the purely combinational 8-bit display path, so the full 10-bit result can be shown without truncation.

---
 rtl/signed_bcd_display_encoder_pkg.sv | 38 +++
 rtl/signed_bcd_display_encoder_if.sv | 25 ++
 rtl/signed_bcd_display_encoder_seg.sv | 30 +++
 rtl/signed_bcd_display_encoder.sv | 129 ++++++++++++
 tb/tb_signed_bcd_display_encoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/signed_bcd_display_encoder_pkg.sv
// Shared types and constants for the signed binary-to-BCD display encoder.
// Holds the FSM encoding, the active-low 7-segment patterns and the sizing helpers.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Active-low segment order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/signed_bcd_display_encoder_if.sv
// Handshake and result bundle between the ALU-side requester and the display encoder.
interface signed_bcd_display_encoder_if #(
    parameter int NBITS   = 10,
    parameter int NDIGITS = 3
);
    logic                   start;
    logic [NBITS-1:0]       value;
    logic                   busy;
    logic                   done;
    logic                   sign;
    logic                   out_of_range;
    logic [4*NDIGITS-1:0]   bcd;
    logic [7*NDIGITS-1:0]   seg;

    modport master (
        output start, value,
        input  busy, done, sign, out_of_range, bcd, seg
    );

    modport slave (
        input  start, value,
        output busy, done, sign, out_of_range, bcd, seg
    );

endinterface

// File: rtl/signed_bcd_display_encoder_seg.sv
// Single-digit BCD to active-low 7-segment decoder with a blanking input.
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assignment first so every path drives seg and no latch is inferred.
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/signed_bcd_display_encoder.sv
// Iterative signed-binary to BCD converter (double-dabble) with registered results
// and leading-zero-blanked active-low 7-segment outputs.
module signed_bcd_display_encoder
    import bcd_display_pkg::*;
#(
    parameter int NBITS   = 10,
    parameter int NDIGITS = 3
) (
    input  logic clk,
    input  logic rst,
    signed_bcd_display_encoder_if.slave bus
);

    localparam int                 CW        = cnt_width(NBITS);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(NBITS - 1);
    localparam longint unsigned    MAX_MAG   = pow10(NDIGITS) - 1;
    localparam logic [4*NDIGITS-1:0] ALL_NINES = {NDIGITS{4'h9}};

    state_t                 state;
    logic [NBITS-1:0]       value_q;
    logic [NBITS-1:0]       mag_q;
    logic [NBITS-1:0]       abs_value;
    logic [4*NDIGITS-1:0]   scr_q;
    logic [4*NDIGITS-1:0]   scr_adj;
    logic [CW-1:0]          cnt_q;
    logic                   sign_q;
    logic                   oor_q;

    logic                   busy_q;
    logic                   done_q;
    logic                   sign_out;
    logic                   oor_out;
    logic [4*NDIGITS-1:0]   bcd_out;
    logic [NDIGITS-1:0]     blank;

    // Unsigned NBITS-bit magnitude: the most negative input maps to 2^(NBITS-1) exactly.
    always_comb begin
        abs_value = value_q[NBITS-1] ? (~value_q + NBITS'(1)) : value_q;
    end

    always_comb begin
        scr_adj = scr_q;
        for (int d = 0; d < NDIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            value_q  <= '0;
            mag_q    <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            oor_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sign_out <= 1'b0;
            oor_out  <= 1'b0;
            bcd_out  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        value_q <= bus.value;
                        busy_q  <= 1'b1;
                        state   <= ABS;
                    end
                end
                ABS: begin
                    mag_q  <= abs_value;
                    sign_q <= value_q[NBITS-1];
                    oor_q  <= 64'(abs_value) > MAX_MAG;
                    scr_q  <= '0;
                    cnt_q  <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {scr_q, mag_q} <= {scr_adj[4*NDIGITS-2:0], mag_q, 1'b0};
                    cnt_q          <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Digits that overflowed the display are meaningless; saturate instead.
                    bcd_out  <= oor_q ? ALL_NINES : scr_q;
                    sign_out <= sign_q;
                    oor_out  <= oor_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Leading-zero blanking runs from the most significant digit down; units never blank.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int d = NDIGITS - 1; d > 0; d--) begin
            lead     = lead & (bcd_out[4*d +: 4] == 4'd0);
            blank[d] = lead;
        end
    end

    for (genvar d = 0; d < NDIGITS; d++) begin : g_digit
        bcd_to_7seg u_seg (
            .nibble (bcd_out[4*d +: 4]),
            .blank  (blank[d]),
            .seg    (bus.seg[7*d +: 7])
        );
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sign         = sign_out;
    assign bus.out_of_range = oor_out;
    assign bus.bcd          = bcd_out;

endmodule

// File: tb/tb_signed_bcd_display_encoder.sv
// Directed self-checking bench for the signed BCD display encoder (3-digit and 2-digit instances).
module tb_signed_bcd_display_encoder;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S5 = 7'h12;
    localparam logic [6:0] S7 = 7'h78, S9 = 7'h10, SB = 7'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    signed_bcd_display_encoder_if #(.NBITS(10), .NDIGITS(3)) if3 ();
    signed_bcd_display_encoder_if #(.NBITS(10), .NDIGITS(2)) if2 ();

    signed_bcd_display_encoder #(.NBITS(10), .NDIGITS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    signed_bcd_display_encoder #(.NBITS(10), .NDIGITS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle (lat=-1 on timeout).
    task automatic convert3(input logic [9:0] v, output int lat);
        if3.start = 1'b1;
        if3.value = v;
        @(posedge clk);
        @(negedge clk);
        if3.start = 1'b0;
        check("busy_after_start3", 32'(if3.busy), 32'd1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if3.done) begin
                lat = k;
                break;
            end
        end
        check("busy_in_done3", 32'(if3.busy), 32'd0);
    endtask

    task automatic convert2(input logic [9:0] v, output int lat);
        if2.start = 1'b1;
        if2.value = v;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if2.done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [11:0] bcd_seen;

        if3.start = 1'b0;
        if3.value = '0;
        if2.start = 1'b0;
        if2.value = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(if3.busy), 32'd0);
        check("rst_done", 32'(if3.done), 32'd0);
        check("rst_sign", 32'(if3.sign), 32'd0);
        check("rst_oor", 32'(if3.out_of_range), 32'd0);
        check("rst_bcd", 32'(if3.bcd), 32'h000);
        check("rst_seg", 32'(if3.seg), 32'({SB, SB, S0}));

        // Zero
        convert3(10'h000, lat);
        check("zero_lat", 32'(lat), 32'd12);
        check("zero_bcd", 32'(if3.bcd), 32'h000);
        check("zero_sign", 32'(if3.sign), 32'd0);
        check("zero_seg", 32'(if3.seg), 32'({SB, SB, S0}));
        @(negedge clk);
        check("done_one_cycle", 32'(if3.done), 32'd0);

        // -5
        convert3(10'h3FB, lat);
        check("m5_lat", 32'(lat), 32'd12);
        check("m5_bcd", 32'(if3.bcd), 32'h005);
        check("m5_sign", 32'(if3.sign), 32'd1);
        check("m5_oor", 32'(if3.out_of_range), 32'd0);
        check("m5_seg", 32'(if3.seg), 32'({SB, SB, S5}));

        // Zero after a negative must clear sign
        convert3(10'h000, lat);
        check("zero2_sign", 32'(if3.sign), 32'd0);

        // -512 (most negative)
        convert3(10'h200, lat);
        check("m512_bcd", 32'(if3.bcd), 32'h512);
        check("m512_sign", 32'(if3.sign), 32'd1);
        check("m512_oor", 32'(if3.out_of_range), 32'd0);
        check("m512_seg", 32'(if3.seg), 32'({S5, S1, S2}));

        // +511
        convert3(10'h1FF, lat);
        check("p511_bcd", 32'(if3.bcd), 32'h511);
        check("p511_sign", 32'(if3.sign), 32'd0);

        // 123, with ignored starts of 77 at edges 3 and 7
        if3.start = 1'b1;
        if3.value = 10'd123;
        @(posedge clk);
        @(negedge clk);
        ndone    = 0;
        lat      = -1;
        bcd_seen = '0;
        for (int k = 1; k <= 12; k++) begin
            if3.start = (k == 3) || (k == 7);
            if3.value = 10'd77;
            @(posedge clk);
            @(negedge clk);
            if (if3.done) begin
                ndone++;
                lat      = k;
                bcd_seen = if3.bcd;
            end
        end
        if3.start = 1'b0;
        check("busy_ign_ndone", 32'(ndone), 32'd1);
        check("busy_ign_lat", 32'(lat), 32'd12);
        check("busy_ign_bcd", 32'(bcd_seen), 32'h123);

        // Start of 77 in the done cycle is accepted
        convert3(10'd77, lat);
        check("b2b_lat", 32'(lat), 32'd12);
        check("b2b_bcd", 32'(if3.bcd), 32'h077);
        check("b2b_seg", 32'(if3.seg), 32'({SB, S7, S7}));

        // 2-digit instance saturation boundary
        convert2(10'd100, lat);
        check("d2_100_lat", 32'(lat), 32'd12);
        check("d2_100_oor", 32'(if2.out_of_range), 32'd1);
        check("d2_100_bcd", 32'(if2.bcd), 32'h99);
        convert2(10'd99, lat);
        check("d2_99_oor", 32'(if2.out_of_range), 32'd0);
        check("d2_99_bcd", 32'(if2.bcd), 32'h99);
        check("d2_99_seg", 32'(if2.seg), 32'({S9, S9}));

        // Reset in the middle of a -300 conversion
        @(negedge clk);
        if3.start = 1'b1;
        if3.value = 10'h2D4;
        @(posedge clk);
        @(negedge clk);
        if3.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(if3.busy), 32'd0);
        check("mid_rst_bcd", 32'(if3.bcd), 32'h000);
        check("mid_rst_sign", 32'(if3.sign), 32'd0);
        check("mid_rst_seg", 32'(if3.seg), 32'({SB, SB, S0}));
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (if3.done) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        check("mid_rst_idle_busy", 32'(if3.busy), 32'd0);

        convert3(10'd300, lat);
        check("p300_lat", 32'(lat), 32'd12);
        check("p300_bcd", 32'(if3.bcd), 32'h300);
        check("p300_sign", 32'(if3.sign), 32'd0);
        check("p300_seg", 32'(if3.seg), 32'({S3, S0, S0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
